// File: rtl/i2s_rx_lock_controller.sv
// i2s_rx_lock_controller: frame-lock qualification and L/R pairing for I2S receive.
// Ports: clk, reset_n (sync, active low), enable; l/r_valid_in strobes with
//   l/r_data_in and bit_cnt_in from the converter; out_valid/out_ready with
//   out_left/out_right stereo handshake; locked, mute, err_count, err_clear, overflow.
module i2s_rx_lock_controller #(
    parameter int unsigned EXP_BIT_CNT    = 31,
    parameter int unsigned LOCK_FRAMES    = 4,
    parameter int unsigned LOSS_ERRORS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        l_valid_in,
    input  logic        r_valid_in,
    input  logic [23:0] l_data_in,
    input  logic [23:0] r_data_in,
    input  logic [7:0]  bit_cnt_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_left,
    output logic [23:0] out_right,
    output logic        locked,
    output logic        mute,
    output logic [15:0] err_count,
    input  logic        err_clear,
    output logic        overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE, S_SEARCH, S_ACQUIRE, S_LOCKED
    } state_e;

    typedef enum logic [1:0] {
        SIDE_NONE, SIDE_L, SIDE_R
    } side_e;

    state_e      state_q, state_d;
    side_e       side_q, side_d;
    logic        half_q, half_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic [TW-1:0] to_q, to_d;
    logic [23:0] lhold_q, lhold_d;
    logic [23:0] left_q, left_d;
    logic [23:0] right_q, right_d;
    logic        valid_q, valid_d;
    logic        locked_q, mute_q;
    logic [15:0] err_q, err_d;
    logic        ovf_q, ovf_d;

    logic strobe, cnt_ok, to_hit;
    logic bad_ev, good_l, good_f;
    logic err_inc, ovf_set;

    assign strobe = l_valid_in | r_valid_in;
    assign cnt_ok = (bit_cnt_in == 8'(EXP_BIT_CNT));
    assign to_hit = !strobe && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        half_d  = half_q;
        good_d  = good_q;
        bad_d   = bad_q;
        lhold_d = lhold_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        to_d    = to_q + TW'(1);
        bad_ev  = 1'b0;
        good_l  = 1'b0;
        good_f  = 1'b0;
        err_inc = 1'b0;
        ovf_set = 1'b0;

        if (strobe || to_hit) to_d = '0;

        // A frame is L then R; an orphan R after an
        // aborted frame is ignored, a repeated R is not.
        if (l_valid_in && r_valid_in) begin
            bad_ev = 1'b1;
            side_d = SIDE_NONE;
        end else if (l_valid_in) begin
            side_d = SIDE_L;
            if (!cnt_ok || half_q) bad_ev = 1'b1;
            else                   good_l = 1'b1;
        end else if (r_valid_in) begin
            side_d = SIDE_R;
            if (side_q == SIDE_R || (half_q && !cnt_ok))
                bad_ev = 1'b1;
            else if (half_q)
                good_f = 1'b1;
        end else if (to_hit) begin
            side_d = SIDE_NONE;
        end

        if (bad_ev || to_hit || good_f) half_d = 1'b0;
        if (good_l) begin
            half_d  = 1'b1;
            lhold_d = l_data_in;
        end

        if (valid_q && out_ready) valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_SEARCH;
                side_d  = SIDE_NONE;
                half_d  = 1'b0;
                good_d  = '0;
                bad_d   = '0;
                to_d    = '0;
                lhold_d = lhold_q;
            end
            S_SEARCH: begin
                // silence here is expected, not an error
                err_inc = bad_ev;
                if (good_l) begin
                    state_d = S_ACQUIRE;
                    good_d  = '0;
                end
            end
            S_ACQUIRE: begin
                err_inc = bad_ev || to_hit;
                if (bad_ev || to_hit) begin
                    state_d = S_SEARCH;
                end else if (good_f) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == 4'(LOCK_FRAMES)) begin
                        state_d = S_LOCKED;
                        bad_d   = '0;
                    end
                end
            end
            S_LOCKED: begin
                err_inc = bad_ev || to_hit;
                if (good_f) begin
                    bad_d   = '0;
                    left_d  = lhold_q;
                    right_d = r_data_in;
                    valid_d = 1'b1;
                    ovf_set = valid_q && !out_ready;
                end else if (bad_ev || to_hit) begin
                    bad_d = bad_q + 4'd1;
                    if (bad_q + 4'd1 == 4'(LOSS_ERRORS))
                        state_d = S_SEARCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d = S_IDLE;
            side_d  = SIDE_NONE;
            half_d  = 1'b0;
            good_d  = '0;
            bad_d   = '0;
            to_d    = '0;
            lhold_d = lhold_q;
            left_d  = left_q;
            right_d = right_q;
            err_inc = 1'b0;
            ovf_set = 1'b0;
        end

        if (state_d != S_LOCKED) valid_d = 1'b0;

        // clear beats a same-cycle error or overwrite
        err_d = err_q;
        if (err_clear)
            err_d = '0;
        else if (err_inc && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;

        ovf_d = err_clear ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            side_q   <= SIDE_NONE;
            half_q   <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
            to_q     <= '0;
            lhold_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            mute_q   <= 1'b1;
            err_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            side_q   <= side_d;
            half_q   <= half_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            to_q     <= to_d;
            lhold_q  <= lhold_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
            locked_q <= (state_q == S_LOCKED);
            mute_q   <= (state_q != S_LOCKED);
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_left  = left_q;
    assign out_right = right_q;
    assign locked    = locked_q;
    assign mute      = mute_q;
    assign err_count = err_q;
    assign overflow  = ovf_q;

endmodule
